// File: rtl/arbitro_escritura_banco.sv
// arbitro_escritura_banco: round-robin write-port arbiter with locked bursts for the register bank.
// Define PRIORIDAD_FIJA_EN for fixed lowest-index priority instead of round-robin.
module arbitro_escritura_banco #(
  parameter int NREQ = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int MAX_BURST = 4,
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1,
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          lock,
  input  logic [NREQ*ADDR_W-1:0]   addr_in,
  input  logic [NREQ*DATA_W-1:0]   data_in,
  output logic [NREQ-1:0]          ack,
  output logic [ADDR_W-1:0]        w_addr,
  output logic                     en_addr,
  output logic [DATA_W-1:0]        w_data,
  output logic [IW-1:0]            grant_id,
  output logic                     busy
);
  typedef enum logic {ARB, LOCKED} state_t;
  state_t state, state_n;
  logic [IW-1:0] ptr, owner, sel, nxt;
  logic [CW-1:0] cnt, cnt_inc;
  logic found, accept, go_lock, rel;
  int idx;
  always_comb begin
    sel = owner;
    found = 1'b0;
    idx = 0;
    if (state == ARB)
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr) + k) % NREQ;
        if (!found && req[idx]) begin
          found = 1'b1;
          sel = IW'(idx);
        end
      end
    ack = '0;
    ack[sel] = rst_n & (state == LOCKED ? req[sel] : found);
    accept = |(req & ack);
    nxt = sel == IW'(NREQ - 1) ? '0 : sel + 1'b1;
    cnt_inc = cnt + 1'b1;
    go_lock = state == ARB && accept && lock[sel] && MAX_BURST > 1;
    // Owner dropping req ends the burst even without a write that cycle
    rel = state == LOCKED && (!req[owner] || (accept && (!lock[owner] || cnt_inc == CW'(MAX_BURST))));
    state_n = go_lock ? LOCKED : rel ? ARB : state;
  end
  assign busy = state == LOCKED;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ARB;
      owner <= '0;
      cnt <= '0;
      en_addr <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
      grant_id <= '0;
    end else begin
      state <= state_n;
      en_addr <= accept;
      if (accept) begin
        w_addr <= addr_in[sel*ADDR_W +: ADDR_W];
        w_data <= data_in[sel*DATA_W +: DATA_W];
        grant_id <= sel;
      end
      if (go_lock) begin
        owner <= sel;
        cnt <= CW'(1);
      end else if (state == LOCKED && accept) cnt <= cnt_inc;
    end
`ifdef PRIORIDAD_FIJA_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if ((state == ARB && accept) || rel) ptr <= nxt;
`endif
endmodule

// File: tb/tb_arbitro_escritura_banco.sv
// tb_arbitro_escritura_banco: directed checks of arbitration, latency, bursts and reset.
module tb_arbitro_escritura_banco;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [3:0] req = '0, lock = '0, ack;
  logic [11:0] addr_in = '0;
  logic [31:0] data_in = '0;
  logic [2:0] w_addr;
  logic en_addr, busy;
  logic [7:0] w_data;
  logic [1:0] grant_id;
  int total = 0, bad = 0;
  arbitro_escritura_banco dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .addr_in(addr_in), .data_in(data_in),
    .ack(ack), .w_addr(w_addr), .en_addr(en_addr), .w_data(w_data), .grant_id(grant_id), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    req = '0;
    lock = '0;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    logic [3:0] exp_ack [5];
    logic       exp_busy [5];
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_en", en_addr, 0);
    chk("rst_addr", w_addr, 0);
    chk("rst_data", w_data, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    chk("idle_en", en_addr, 0);
    req = 4'b0100;
    addr_in[6 +: 3] = 3'b101;
    data_in[16 +: 8] = 8'hA5;
    #1 chk("single_ack", ack, 4'b0100);
    tick;
    req = '0;
    chk("single_en", en_addr, 1);
    chk("single_addr", w_addr, 5);
    chk("single_data", w_data, 8'hA5);
    chk("single_gid", grant_id, 2);
    tick;
    chk("single_en_off", en_addr, 0);
    chk("single_hold", w_data, 8'hA5);
    do_reset;
    addr_in = {3'd3, 3'd2, 3'd1, 3'd0};
    data_in = 32'h13121110;
    req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1 chk($sformatf("rr_ack%0d", c), ack, 4'b0001 << (c % 4));
      if (c > 0) begin
        chk($sformatf("rr_en%0d", c), en_addr, 1);
        chk($sformatf("rr_gid%0d", c), grant_id, (c - 1) % 4);
        chk($sformatf("rr_data%0d", c), w_data, 8'h10 + (c - 1) % 4);
      end
      tick;
    end
    do_reset;
    req = 4'b1010;
    lock = 4'b0010;
    exp_ack = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000};
    exp_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 5; c++) begin
      #1 chk($sformatf("burst_ack%0d", c), ack, exp_ack[c]);
      chk($sformatf("burst_busy%0d", c), busy, exp_busy[c]);
      tick;
    end
    chk("burst_last_gid", grant_id, 3);
    #1 chk("burst_again", ack, 4'b0010);
    tick;
    chk("midreset_busy_pre", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_en", en_addr, 0);
    chk("midreset_ack", ack, 0);
    do_reset;
    req = 4'b0101;
    lock = 4'b0001;
    #1 chk("early_ack0", ack, 4'b0001);
    tick;
    chk("early_busy1", busy, 1);
    #1 chk("early_ack1", ack, 4'b0001);
    tick;
    req = 4'b0100;
    #1 chk("early_idle_ack", ack, 4'b0000);
    tick;
    chk("early_busy_fall", busy, 0);
    chk("early_en_gap", en_addr, 0);
    req = 4'b0101;
    #1 chk("early_ptr1", ack, 4'b0100);
    tick;
    chk("early_gid", grant_id, 2);
    do_reset;
    req = 4'b0110;
    for (int c = 0; c < 4; c++) begin
`ifdef PRIORIDAD_FIJA_EN
      #1 chk($sformatf("fixed_ack%0d", c), ack, 4'b0010);
`else
      #1 chk($sformatf("pair_ack%0d", c), ack, c % 2 == 0 ? 4'b0010 : 4'b0100);
`endif
      tick;
    end
    req = '0;
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/arbitro_escritura_banco.md
Name: arbitro_escritura_banco

Overview:
- Round-robin arbiter for the register bank's single write port, shared by NREQ requesters (ALU writeback, load unit, external loader, etc.).
- Accepts per-requester write requests with a valid/ack handshake.
- Drives registered w_addr/en_addr/w_data straight into the bank's 3-to-8 write decoder and register array.
- Supports locked bursts: one requester holds the port for up to MAX_BURST consecutive writes.

Parameters:
- NREQ, 4, number of requesters; 2..8.
- DATA_W, 8, register data width.
- ADDR_W, 3, register address width; 3 selects one of 8 bank registers.
- MAX_BURST, 4, maximum consecutive accepted writes per lock; >=1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  write request per requester; addr/data stable while req=1.
- lock  in  NREQ  requester asks to keep the port after this write.
- addr_in  in  NREQ*ADDR_W  packed target addresses; requester i at [i*ADDR_W +: ADDR_W].
- data_in  in  NREQ*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W].
- ack  out  NREQ  combinational one-hot grant; write i accepted at the edge where req[i]&ack[i].
- w_addr  out  ADDR_W  registered write address to decoder.
- en_addr  out  1  registered write enable to decoder.
- w_data  out  DATA_W  registered write data to bank.
- grant_id  out  clog2(NREQ)  registered index of the requester owning the current write.
- busy  out  1  1 while FSM in LOCKED.

Behaviour:
- Reset (rst_n=0, async): en_addr=0, w_addr=0, w_data=0, grant_id=0, busy=0, ack=0, FSM=ARB, rr pointer=0, burst counter=0.
- ack is at most one-hot and is 0 whenever req is 0; ack[i]=1 only if req[i]=1.
- Latency: a write accepted at edge N appears as en_addr=1 with matching w_addr/w_data/grant_id during cycle N+1 (one cycle).
- No accepted write at an edge -> en_addr=0 next cycle; w_addr/w_data/grant_id hold their last values.
- Back-to-back: a requester holding req=1 after ack gets successive writes, subject to arbitration.
- FSM state ARB:
  - Winner = first i with req[i]=1, searching from rr pointer upward with wrap (pointer, pointer+1, ..., NREQ-1, 0, ...).
  - ack[winner]=1.
  - On acceptance: pointer <= (winner+1) mod NREQ.
  - If lock[winner]=1 and MAX_BURST>1: go to LOCKED, owner <= winner, burst counter <= 1.
  - Otherwise stay in ARB.
- FSM state LOCKED:
  - Only owner can be granted: ack[owner]=req[owner]; all other acks are 0.
  - Each accepted owner write increments burst counter.
  - Release to ARB when any of the following holds:
    - (a) an accepted owner write has lock[owner]=0;
    - (b) req[owner]=0 in any LOCKED cycle; no write that cycle, ARB resumes next cycle;
    - (c) the accepted write brings the counter to MAX_BURST (forced release).
  - pointer <= (owner+1) mod NREQ on release.
- Equal addresses from several requesters in the same cycle: only the winner writes; the others are served in later cycles in round-robin order. The last writer is the later-granted one. No merging.
- Counter width: clog2(MAX_BURST+1); never exceeds MAX_BURST.
- Reset mid-burst: immediate return to reset values. Writes already registered but not yet presented are dropped; requesters must re-request.
- Starvation bound in ARB: any requester holding req is acked within NREQ-1 grants of others. With locks, within (NREQ-1)*MAX_BURST accepted writes.

Optional Feature:
- Macro: PRIORIDAD_FIJA_EN.
- Defined:
  - Fixed priority; lowest index always wins in ARB.
  - rr pointer not implemented and held at 0.
  - LOCKED behaviour and MAX_BURST limit unchanged; after release, the lowest-index requester wins again.
- Undefined: round-robin as above.

Test Plan:
- Reset values: assert rst_n=0 mid-cycle -> all outputs 0 immediately. Release, req=0 -> en_addr stays 0.
- Single write: req[2]=1, addr_in[2]=3'b101, data_in[2]=8'hA5 -> ack=4'b0100 same cycle. Next cycle en_addr=1, w_addr=5, w_data=8'hA5, grant_id=2; then en_addr=0.
- Round-robin: req=4'b1111 held for 8 cycles from reset -> ack sequence 0,1,2,3,0,1,2,3. en_addr=1 every cycle after the first, grant_id following one cycle behind.
- Burst lock, MAX_BURST=4: req[1]=1 and lock[1]=1 held, req[3]=1 -> four grants to 1 with busy=1, forced release, then ack[3]. Requester 3 granted before 1 again.
- Early release: lock[0]=1 then req[0] dropped after 2 writes while req[2]=1 -> one idle cycle, busy falls, next grant to 2, pointer=1.
- PRIORIDAD_FIJA_EN defined, req=4'b0110 held -> ack always 4'b0010; requester 2 never granted while req[1]=1.
